mby_igr_epl_shim_seg_asm: RTL and testbench

//  Parametrised IGR EPL shim segment assembler with output queue. Steers N_LANES
//  ECC-protected words from one EPL receive beat into a segment buffer, using a
//  per-lane select and write-enable. It merges metadata for a deferred SOP and

---
 rtl/mby_igr_epl_shim_seg_asm.sv | 190 +++++++++++++++++++
 tb/tb_mby_igr_epl_shim_seg_asm.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mby_igr_epl_shim_seg_asm.sv
// IGR EPL shim segment assembler: steers one EPL beat into a segment
// buffer, merges deferred-SOP metadata and queues segments for the PB.

package mby_igr_epl_shim_pkg;

  typedef logic [31:0] epl_ts_t;

  typedef struct packed {
    logic       multi;
    logic       fast;
    logic       fcs_hint;
    logic       dei;
    logic       sop;
    logic       eop;
    logic [1:0] error;
    logic [2:0] tc;
    logic [2:0] eop_pos;
    logic [2:0] byte_pos;
    logic [2:0] sop_pos;
  } epl_md_t;

  typedef struct packed {
    epl_ts_t ts;
    epl_md_t md;
  } shim_ts_md_t;

endpackage

module mby_igr_epl_shim_seg_asm
  import mby_igr_epl_shim_pkg::*;
#(
  parameter int unsigned N_LANES    = 8,
  parameter int unsigned LANE_W     = 72,
  parameter int unsigned SEL_W      = $clog2(N_LANES) + 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  PAD_ECC    = 8'h06
) (
  input  logic                            cclk,
  input  logic                            rst,
  input  logic [N_LANES*LANE_W-1:0]       i_rx_data,
  input  epl_ts_t                         i_rx_ts,
  input  epl_md_t                         i_seg_md,
  input  logic [N_LANES*SEL_W-1:0]        i_seg_sel,
  input  logic [N_LANES-1:0]              i_seg_we,
  input  logic                            i_seg_sop_e,
  input  logic                            i_seg_e,
  input  logic                            i_seg_ready,
  output logic                            o_seg_valid,
  output logic [N_LANES*LANE_W-1:0]       o_seg_data,
  output shim_ts_md_t                     o_seg_ts_md,
  output logic [$clog2(FIFO_DEPTH):0]     o_fifo_cnt,
  output logic                            o_ovf
);

  localparam int LIDX_W = $clog2(N_LANES);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SEG_W  = N_LANES * LANE_W;

  localparam logic [LANE_W-1:0] PAD =
    LANE_W'({PAD_ECC, 64'h0});
  localparam logic [SEG_W-1:0] PAD_SEG =
    {N_LANES{PAD}};

  logic [LANE_W-1:0] rx_lane [N_LANES];
  logic [LANE_W-1:0] src     [N_LANES];
  logic [LANE_W-1:0] mrg     [N_LANES];
  logic [LANE_W-1:0] asm_q   [N_LANES];
  logic [SEG_W-1:0]  mrg_flat;

  logic              pend_sop;
  logic [1:0]        pend_err;
  logic [2:0]        pend_tc;
  epl_ts_t           pend_ts;
  shim_ts_md_t       push_tm;

  logic [SEG_W-1:0]  mem_data [FIFO_DEPTH];
  shim_ts_md_t       mem_tm   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              full;
  logic              pop;
  logic              push;
  logic [SEG_W-1:0]  head_data_d;
  shim_ts_md_t       head_tm_d;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    logic [SEL_W-1:0] sel;
    assign sel        = i_seg_sel[k*SEL_W +: SEL_W];
    assign rx_lane[k] = i_rx_data[k*LANE_W +: LANE_W];
    assign src[k]     = (sel < SEL_W'(N_LANES)) ?
                        rx_lane[sel[LIDX_W-1:0]] : PAD;
    assign mrg[k]     = i_seg_we[k] ? src[k] : asm_q[k];
    assign mrg_flat[k*LANE_W +: LANE_W] = mrg[k];
  end

  // Pushed metadata: a pending SOP overrides sop/tc/ts of the closing beat.
  always_comb begin
    push_tm          = '0;
    push_tm.md       = i_seg_md;
    push_tm.md.error = pend_err | i_seg_md.error;
    push_tm.ts       = i_rx_ts;
    if (pend_sop) begin
      push_tm.md.sop = 1'b1;
      push_tm.md.tc  = pend_tc;
      push_tm.ts     = pend_ts;
    end
  end

  // Assembly buffer: hold merged lanes, restart as all pad after a segment.
  always_ff @(posedge cclk) begin
    for (int k = 0; k < N_LANES; k++) begin
      if (rst || i_seg_e) asm_q[k] <= PAD;
      else                asm_q[k] <= mrg[k];
    end
  end

  // Pending SOP: a new capture beats a clear since it opens the next segment.
  always_ff @(posedge cclk) begin
    if (rst) begin
      pend_sop <= 1'b0;
      pend_err <= '0;
      pend_tc  <= '0;
      pend_ts  <= '0;
    end else if (i_seg_sop_e) begin
      pend_sop <= i_seg_md.sop;
      pend_err <= i_seg_md.error;
      pend_tc  <= i_seg_md.tc;
      pend_ts  <= i_rx_ts;
    end else if (i_seg_e) begin
      pend_sop <= 1'b0;
      pend_err <= '0;
      pend_tc  <= '0;
      pend_ts  <= '0;
    end
  end

  assign full    = (o_fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign pop     = o_seg_valid & i_seg_ready;
  assign push    = i_seg_e & (~full | pop);
  assign rd_nxt  = rd_ptr + PTR_W'(pop);
  assign cnt_nxt = o_fifo_cnt + CNT_W'(push) - CNT_W'(pop);

  // Next head: bypass the pushed segment when it lands in the head slot.
  always_comb begin
    head_data_d = PAD_SEG;
    head_tm_d   = '0;
    if (cnt_nxt != '0) begin
      if (push && (wr_ptr == rd_nxt)) begin
        head_data_d = mrg_flat;
        head_tm_d   = push_tm;
      end else begin
        head_data_d = mem_data[rd_nxt];
        head_tm_d   = mem_tm[rd_nxt];
      end
    end
  end

  // Queue storage; entries are only read while valid, so no reset needed.
  always_ff @(posedge cclk) begin
    if (!rst && push) begin
      mem_data[wr_ptr] <= mrg_flat;
      mem_tm[wr_ptr]   <= push_tm;
    end
  end

  // Pointers, occupancy, registered head and overflow pulse.
  always_ff @(posedge cclk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_fifo_cnt  <= '0;
      o_seg_valid <= 1'b0;
      o_seg_data  <= PAD_SEG;
      o_seg_ts_md <= '0;
      o_ovf       <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + PTR_W'(push);
      rd_ptr      <= rd_nxt;
      o_fifo_cnt  <= cnt_nxt;
      o_seg_valid <= (cnt_nxt != '0);
      o_seg_data  <= head_data_d;
      o_seg_ts_md <= head_tm_d;
      o_ovf       <= i_seg_e & full & ~pop;
    end
  end

endmodule

// File: tb/tb_mby_igr_epl_shim_seg_asm.sv
// Bench for the IGR EPL shim segment assembler: directed scenarios plus
// randomized traffic against a queue-based reference model.

module tb_mby_igr_epl_shim_seg_asm;
  import mby_igr_epl_shim_pkg::*;

  localparam int MDW = $bits(epl_md_t);
  localparam logic [71:0]  PAD    = {8'h06, 64'h0};
  localparam logic [575:0] PADSEG = {8{PAD}};

  typedef struct packed {
    logic [575:0] data;
    shim_ts_md_t  tm;
  } seg_t;

  logic         cclk;
  logic         rst;
  logic [575:0] rx_data;
  epl_ts_t      rx_ts;
  epl_md_t      seg_md;
  logic [31:0]  seg_sel;
  logic [7:0]   seg_we;
  logic         sop_e;
  logic         seg_e;
  logic         ready;
  logic         o_seg_valid;
  logic [575:0] o_seg_data;
  shim_ts_md_t  o_seg_ts_md;
  logic [2:0]   o_fifo_cnt;
  logic         o_ovf;

  int total = 0;
  int bad   = 0;

  logic [71:0] m_asm [8];
  bit          m_pend_sop;
  logic [1:0]  m_pend_err;
  logic [2:0]  m_pend_tc;
  epl_ts_t     m_pend_ts;
  seg_t        m_q [$];
  bit          m_ovf;

  mby_igr_epl_shim_seg_asm dut (
    .cclk        (cclk),
    .rst         (rst),
    .i_rx_data   (rx_data),
    .i_rx_ts     (rx_ts),
    .i_seg_md    (seg_md),
    .i_seg_sel   (seg_sel),
    .i_seg_we    (seg_we),
    .i_seg_sop_e (sop_e),
    .i_seg_e     (seg_e),
    .i_seg_ready (ready),
    .o_seg_valid (o_seg_valid),
    .o_seg_data  (o_seg_data),
    .o_seg_ts_md (o_seg_ts_md),
    .o_fifo_cnt  (o_fifo_cnt),
    .o_ovf       (o_ovf)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  task automatic model_step();
    seg_t s;
    bit full;
    bit pop;
    if (rst) begin
      for (int k = 0; k < 8; k++) m_asm[k] = PAD;
      m_pend_sop = 0;
      m_pend_err = '0;
      m_pend_tc  = '0;
      m_pend_ts  = '0;
      m_q.delete();
      m_ovf = 0;
      return;
    end
    s = '0;
    for (int k = 0; k < 8; k++) begin
      int sv;
      logic [71:0] lane;
      sv = int'(seg_sel[k*4 +: 4]);
      lane = (sv < 8) ? rx_data[sv*72 +: 72] : PAD;
      if (!seg_we[k]) lane = m_asm[k];
      s.data[k*72 +: 72] = lane;
    end
    s.tm.md = seg_md;
    s.tm.md.error = m_pend_err | seg_md.error;
    s.tm.ts = rx_ts;
    if (m_pend_sop) begin
      s.tm.md.sop = 1'b1;
      s.tm.md.tc  = m_pend_tc;
      s.tm.ts     = m_pend_ts;
    end
    full  = (m_q.size() == 4);
    pop   = (m_q.size() != 0) && ready;
    m_ovf = seg_e && full && !pop;
    if (pop) void'(m_q.pop_front());
    if (seg_e && !m_ovf) m_q.push_back(s);
    for (int k = 0; k < 8; k++)
      m_asm[k] = seg_e ? PAD : s.data[k*72 +: 72];
    if (sop_e) begin
      m_pend_sop = seg_md.sop;
      m_pend_err = seg_md.error;
      m_pend_tc  = seg_md.tc;
      m_pend_ts  = rx_ts;
    end else if (seg_e) begin
      m_pend_sop = 0;
      m_pend_err = '0;
      m_pend_tc  = '0;
      m_pend_ts  = '0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge cclk);
    #1;
  endtask

  task automatic idle();
    seg_we = '0;
    sop_e  = 0;
    seg_e  = 0;
    ready  = 0;
    seg_md = '0;
    rx_ts  = '0;
  endtask

  task automatic set_sel_id();
    for (int k = 0; k < 8; k++) seg_sel[k*4 +: 4] = 4'(k);
  endtask

  task automatic rand_data();
    for (int k = 0; k < 18; k++) rx_data[k*32 +: 32] = $urandom;
  endtask

  task automatic drain();
    idle();
    ready = 1;
    for (int i = 0; i < 6; i++) tick();
    ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    rand_data();
    set_sel_id();
    seg_we = 8'hFF;
    sop_e = 1;
    seg_e = 1;
    ready = 1;
    tick();
    tick();
    total++;
    if (o_seg_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got=%0b want=0", o_seg_valid);
    end
    total++;
    if (o_fifo_cnt !== 3'd0) begin
      bad++;
      $display("FAIL reset_cnt got=%0d want=0", o_fifo_cnt);
    end
    total++;
    if (o_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf got=%0b want=0", o_ovf);
    end
    total++;
    if (o_seg_ts_md !== '0) begin
      bad++;
      $display("FAIL reset_tsmd got=%h want=0", o_seg_ts_md);
    end
    total++;
    if (o_seg_data !== PADSEG) begin
      bad++;
      $display("FAIL reset_data got=%h want=%h", o_seg_data, PADSEG);
    end
    idle();
    rst = 0;
    tick();
  endtask

  task automatic test_identity();
    logic [575:0] d;
    idle();
    rand_data();
    d = rx_data;
    set_sel_id();
    seg_we = 8'hFF;
    seg_e = 1;
    ready = 1;
    tick();
    total++;
    if (o_seg_valid !== 1'b1 || o_seg_data !== d) begin
      bad++;
      $display("FAIL ident_head v=%0b got=%h want=%h",
               o_seg_valid, o_seg_data, d);
    end
    seg_e = 0;
    seg_we = '0;
    tick();
    total++;
    if (o_fifo_cnt !== 3'd0 || o_seg_valid !== 1'b0) begin
      bad++;
      $display("FAIL ident_pop cnt=%0d v=%0b want 0/0",
               o_fifo_cnt, o_seg_valid);
    end
    total++;
    if (o_seg_data !== PADSEG) begin
      bad++;
      $display("FAIL ident_pad got=%h want=%h", o_seg_data, PADSEG);
    end
  endtask

  task automatic test_partial();
    logic [575:0] a;
    logic [575:0] exp;
    idle();
    set_sel_id();
    rand_data();
    a = rx_data;
    seg_we = 8'h0F;
    tick();
    rand_data();
    exp = a;
    exp[575:288] = rx_data[575:288];
    seg_we = 8'hF0;
    seg_e = 1;
    tick();
    total++;
    if (o_seg_data !== exp) begin
      bad++;
      $display("FAIL partial_merge got=%h want=%h", o_seg_data, exp);
    end
    drain();
    set_sel_id();
    rand_data();
    exp = PADSEG;
    exp[143:0] = rx_data[143:0];
    seg_we = 8'h03;
    seg_e = 1;
    tick();
    total++;
    if (o_seg_data !== exp) begin
      bad++;
      $display("FAIL partial_pad got=%h want=%h", o_seg_data, exp);
    end
    drain();
  endtask

  task automatic test_deferred_sop();
    idle();
    set_sel_id();
    rand_data();
    seg_we = 8'hFF;
    seg_md.sop = 1;
    seg_md.tc = 3'd5;
    seg_md.error = 2'b01;
    rx_ts = 32'hAAAA_0001;
    sop_e = 1;
    tick();
    idle();
    seg_md.tc = 3'd2;
    seg_md.error = 2'b10;
    rx_ts = 32'hBBBB_0002;
    seg_e = 1;
    tick();
    total++;
    if (o_seg_ts_md.md.sop !== 1'b1 || o_seg_ts_md.md.tc !== 3'd5 ||
        o_seg_ts_md.ts !== 32'hAAAA_0001 ||
        o_seg_ts_md.md.error !== 2'b11) begin
      bad++;
      $display("FAIL dsop_merge got sop=%0b tc=%0d ts=%h err=%b want 1/5/aaaa0001/11",
               o_seg_ts_md.md.sop, o_seg_ts_md.md.tc,
               o_seg_ts_md.ts, o_seg_ts_md.md.error);
    end
    drain();
    seg_md.sop = 1;
    seg_md.tc = 3'd3;
    rx_ts = 32'hCCCC_0003;
    sop_e = 1;
    seg_e = 1;
    tick();
    idle();
    seg_md.tc = 3'd6;
    rx_ts = 32'hDDDD_0004;
    seg_e = 1;
    ready = 1;
    tick();
    total++;
    if (o_seg_ts_md.md.sop !== 1'b1 || o_seg_ts_md.md.tc !== 3'd3 ||
        o_seg_ts_md.ts !== 32'hCCCC_0003 || o_fifo_cnt !== 3'd1) begin
      bad++;
      $display("FAIL dsop_same_cycle got sop=%0b tc=%0d ts=%h cnt=%0d want 1/3/cccc0003/1",
               o_seg_ts_md.md.sop, o_seg_ts_md.md.tc,
               o_seg_ts_md.ts, o_fifo_cnt);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [575:0] d [6];
    idle();
    set_sel_id();
    seg_we = 8'hFF;
    seg_e = 1;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      d[i] = rx_data;
      tick();
      if (i == 0) begin
        total++;
        if (o_seg_data !== d[0]) begin
          bad++;
          $display("FAIL bp_first got=%h want=%h", o_seg_data, d[0]);
        end
      end
    end
    total++;
    if (o_fifo_cnt !== 3'd4 || o_ovf !== 1'b1) begin
      bad++;
      $display("FAIL bp_ovf cnt=%0d ovf=%0b want 4/1", o_fifo_cnt, o_ovf);
    end
    total++;
    if (o_seg_data !== d[0]) begin
      bad++;
      $display("FAIL bp_stable got=%h want=%h", o_seg_data, d[0]);
    end
    seg_e = 0;
    tick();
    total++;
    if (o_ovf !== 1'b0 || o_fifo_cnt !== 3'd4) begin
      bad++;
      $display("FAIL bp_pulse ovf=%0b cnt=%0d want 0/4", o_ovf, o_fifo_cnt);
    end
    rand_data();
    d[5] = rx_data;
    seg_e = 1;
    ready = 1;
    tick();
    total++;
    if (o_ovf !== 1'b0 || o_fifo_cnt !== 3'd4 || o_seg_data !== d[1]) begin
      bad++;
      $display("FAIL bp_full_pushpop ovf=%0b cnt=%0d want 0/4 head_ok=%0b",
               o_ovf, o_fifo_cnt, o_seg_data === d[1]);
    end
    seg_e = 0;
    for (int i = 0; i < 3; i++) begin
      logic [575:0] w;
      tick();
      w = (i == 2) ? d[5] : d[i+2];
      total++;
      if (o_seg_data !== w) begin
        bad++;
        $display("FAIL bp_order idx=%0d got=%h want=%h", i, o_seg_data, w);
      end
    end
    tick();
    total++;
    if (o_fifo_cnt !== 3'd0 || o_seg_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_empty cnt=%0d v=%0b want 0/0", o_fifo_cnt, o_seg_valid);
    end
    idle();
  endtask

  task automatic test_pad_select();
    logic [575:0] exp;
    idle();
    set_sel_id();
    seg_sel[3*4 +: 4] = 4'd8;
    seg_sel[5*4 +: 4] = 4'd15;
    rand_data();
    exp = rx_data;
    exp[3*72 +: 72] = PAD;
    exp[5*72 +: 72] = PAD;
    seg_we = 8'hFF;
    seg_e = 1;
    tick();
    total++;
    if (o_seg_data !== exp) begin
      bad++;
      $display("FAIL pad_sel got=%h want=%h", o_seg_data, exp);
    end
    drain();
    set_sel_id();
  endtask

  task automatic test_reset_mid();
    idle();
    set_sel_id();
    seg_we = 8'hFF;
    seg_e = 1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      tick();
    end
    idle();
    seg_md.sop = 1;
    seg_md.tc = 3'd7;
    rx_ts = 32'hEEEE_0005;
    sop_e = 1;
    tick();
    total++;
    if (o_fifo_cnt !== 3'd3) begin
      bad++;
      $display("FAIL rstmid_pre cnt=%0d want 3", o_fifo_cnt);
    end
    rst = 1;
    seg_e = 1;
    ready = 1;
    tick();
    rst = 0;
    idle();
    total++;
    if (o_seg_valid !== 1'b0 || o_fifo_cnt !== 3'd0 || o_ovf !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_clr v=%0b cnt=%0d ovf=%0b want 0/0/0",
               o_seg_valid, o_fifo_cnt, o_ovf);
    end
    rand_data();
    seg_we = 8'hFF;
    seg_md.tc = 3'd1;
    rx_ts = 32'hFFFF_0006;
    seg_e = 1;
    tick();
    total++;
    if (o_seg_ts_md.md.sop !== 1'b0 || o_seg_ts_md.md.tc !== 3'd1 ||
        o_seg_ts_md.ts !== 32'hFFFF_0006) begin
      bad++;
      $display("FAIL rstmid_sop got sop=%0b tc=%0d ts=%h want 0/1/ffff0006",
               o_seg_ts_md.md.sop, o_seg_ts_md.md.tc, o_seg_ts_md.ts);
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      bit ev;
      logic [575:0] ed;
      shim_ts_md_t et;
      rand_data();
      rx_ts  = $urandom;
      seg_md = MDW'($urandom);
      for (int k = 0; k < 8; k++)
        seg_sel[k*4 +: 4] = ($urandom_range(0, 7) == 0) ?
                            4'($urandom_range(8, 15)) :
                            4'($urandom_range(0, 7));
      seg_we = 8'($urandom);
      sop_e  = ($urandom_range(0, 3) == 0);
      seg_e  = ($urandom_range(0, 1) == 0);
      ready  = ($urandom_range(0, 2) == 0);
      rst    = ($urandom_range(0, 99) == 0);
      tick();
      ev = (m_q.size() != 0);
      ed = ev ? m_q[0].data : PADSEG;
      et = ev ? m_q[0].tm : '0;
      total++;
      if (o_seg_valid !== ev) begin
        bad++;
        $display("FAIL rand_valid cyc=%0d got=%0b want=%0b", c, o_seg_valid, ev);
      end
      total++;
      if (o_fifo_cnt !== 3'(m_q.size())) begin
        bad++;
        $display("FAIL rand_cnt cyc=%0d got=%0d want=%0d", c, o_fifo_cnt, m_q.size());
      end
      total++;
      if (o_ovf !== m_ovf) begin
        bad++;
        $display("FAIL rand_ovf cyc=%0d got=%0b want=%0b", c, o_ovf, m_ovf);
      end
      total++;
      if (o_seg_data !== ed) begin
        bad++;
        $display("FAIL rand_data cyc=%0d got=%h want=%h", c, o_seg_data, ed);
      end
      total++;
      if (o_seg_ts_md !== et) begin
        bad++;
        $display("FAIL rand_tsmd cyc=%0d got=%h want=%h", c, o_seg_ts_md, et);
      end
    end
    rst = 0;
    drain();
  endtask

  initial begin
    rst = 1;
    rx_data = '0;
    seg_sel = '0;
    idle();
    test_reset();
    test_identity();
    test_partial();
    test_deferred_sop();
    test_back_to_back();
    test_pad_select();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
